// File: rtl/sar_seq_pkg.sv
// Shared types for the SAR conversion-phase sequencer.
package sar_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SAMP,
        COMP,
        UPDATE,
        DONE
    } seq_state_t;

    // Index width that stays at least one bit wide for tiny NBITS.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sar_phase_cnt.sv
// Loadable down-counter timing the INIT and SAMP phases; tc_o flags zero.
module sar_phase_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    // Saturates at zero so a phase that overstays never wraps.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/sar_sequencer.sv
// SAR ADC conversion-phase sequencer driving the clock-gate stage.
// Optional back-to-back conversions when SAR_SEQ_CONT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start
// INIT   | DAC init strobe, INIT_CYC cycles
// SAMP   | sampling strobe, SAMP_CYC cycles
// COMP   | comparator strobe for bit_idx, 1 cycle
// UPDATE | DAC update strobe for bit_idx, 1 cycle
// DONE   | done pulse, 1 cycle
module sar_sequencer
    import sar_seq_pkg::*;
#(
    parameter int NBITS    = 8,
    parameter int INIT_CYC = 1,
    parameter int SAMP_CYC = 4,
    parameter int CNT_W    = 8,
    parameter int IDX_W    = clog2_min1(NBITS)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             abort_i,
`ifdef SAR_SEQ_CONT_EN
    input  logic             cont_i,
`endif
    output logic             seq_init_o,
    output logic             seq_samp_o,
    output logic             seq_comp_o,
    output logic             seq_update_o,
    output logic [IDX_W-1:0] bit_idx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [IDX_W-1:0] BIT_MSB   = IDX_W'(NBITS - 1);
    localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_CYC - 1);
    localparam logic [CNT_W-1:0] SAMP_LOAD = CNT_W'(SAMP_CYC - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             seq_init_q, seq_samp_q, seq_comp_q, seq_update_q;
    logic             busy_q, done_q;
    logic             cnt_load, cnt_en, cnt_tc, cont_req;
    logic [CNT_W-1:0] cnt_load_val;

`ifdef SAR_SEQ_CONT_EN
    assign cont_req = cont_i;
`else
    assign cont_req = 1'b0;
`endif

    sar_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .tc_o       (cnt_tc)
    );

    assign cnt_en = (state_q == INIT) || (state_q == SAMP);

    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    state_d      = INIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = INIT_LOAD;
                end
            end
            INIT: begin
                if (cnt_tc) begin
                    state_d      = SAMP;
                    cnt_load     = 1'b1;
                    cnt_load_val = SAMP_LOAD;
                end
            end
            SAMP: begin
                if (cnt_tc) begin
                    state_d   = COMP;
                    bit_idx_d = BIT_MSB;
                end
            end
            COMP: state_d = UPDATE;
            UPDATE: begin
                if (bit_idx_q != '0) begin
                    state_d   = COMP;
                    bit_idx_d = bit_idx_q - 1'b1;
                end else begin
                    state_d   = DONE;
                    bit_idx_d = BIT_MSB;
                end
            end
            DONE: begin
                if (cont_req) begin
                    state_d      = INIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = INIT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort beats every other transition, including a continuous restart.
        if (abort_i && (state_q != IDLE)) begin
            state_d   = IDLE;
            bit_idx_d = BIT_MSB;
            cnt_load  = 1'b0;
        end
    end

    // Outputs are flops decoded from the next state so the gates see clean edges.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            bit_idx_q    <= BIT_MSB;
            seq_init_q   <= 1'b0;
            seq_samp_q   <= 1'b0;
            seq_comp_q   <= 1'b0;
            seq_update_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            seq_init_q   <= (state_d == INIT);
            seq_samp_q   <= (state_d == SAMP);
            seq_comp_q   <= (state_d == COMP);
            seq_update_q <= (state_d == UPDATE);
            busy_q       <= (state_d == INIT) || (state_d == SAMP) ||
                            (state_d == COMP) || (state_d == UPDATE);
            done_q       <= (state_d == DONE);
        end
    end

    assign seq_init_o   = seq_init_q;
    assign seq_samp_o   = seq_samp_q;
    assign seq_comp_o   = seq_comp_q;
    assign seq_update_o = seq_update_q;
    assign bit_idx_o    = bit_idx_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
